// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: segment width, stage count helper and
// the per-stage pipeline payload used by the segmented borrow-chain datapath.
package arith_pkg;

    localparam int unsigned SEG_W = 8;

    function automatic int unsigned nstg(input int unsigned width);
        return width / SEG_W;
    endfunction

    // Payload held between segments: result slice, chain carry, running zero, valid.
    typedef struct packed {
        logic [SEG_W-1:0] d;
        logic             c;
        logic             z;
        logic             v;
    } stage_t;

endpackage

// File: rtl/sub_seg8.sv
// Combinational 8-bit borrow-chain slice: d = x + ~y + ci, built as a
// per-bit propagate/generate mux chain; zero flags an all-zero slice.
module sub_seg8
    import arith_pkg::*;
(
    input  logic [SEG_W-1:0] x,
    input  logic [SEG_W-1:0] y,
    input  logic             ci,
    output logic [SEG_W-1:0] d,
    output logic             co,
    output logic             zero
);

    logic [SEG_W:0] c;

    always_comb begin
        c    = '0;
        d    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(SEG_W); i++) begin
            // Propagate selects the incoming carry, otherwise the bit generates.
            d[i]   = (x[i] ^ ~y[i]) ^ c[i];
            c[i+1] = (x[i] ^ ~y[i]) ? c[i] : (x[i] & ~y[i]);
        end
        co   = c[SEG_W];
        zero = (d == '0);
    end

endmodule

// File: rtl/pipe_sub_cmp.sv
// Pipelined wide subtractor/comparator, one 8-bit borrow segment per stage with
// input skew and output deskew. Define PIPE_SUB_CMP_OVF_EN to add the ovf output.
module pipe_sub_cmp
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             eq
`ifdef PIPE_SUB_CMP_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSTG = nstg(WIDTH);
    localparam int          LAST = int'(NSTG) - 1;

    if (WIDTH < SEG_W || (WIDTH % SEG_W) != 0) begin : g_width_chk
        $error("pipe_sub_cmp: WIDTH must be a positive multiple of 8");
    end

    logic   en;
    stage_t stg [NSTG];

    assign en        = out_ready | ~out_valid;
    assign in_ready  = en & ~reset;
    assign out_valid = stg[LAST].v;
    assign bout      = stg[LAST].c;
    assign eq        = stg[LAST].z;

    for (genvar k = 0; k < int'(NSTG); k++) begin : g_stg
        logic [SEG_W-1:0] x, y, d;
        logic             ci, zin, vin, co, zero;
        stage_t           q;

        if (k == 0) begin : g_first
            assign x   = a[SEG_W-1:0];
            assign y   = b[SEG_W-1:0];
            assign ci  = ~bin;
            assign zin = 1'b1;
            assign vin = in_valid;
        end else begin : g_rest
            // Operand skew: segment k waits k cycles for the carry to arrive.
            logic [SEG_W-1:0] a_sk [k];
            logic [SEG_W-1:0] b_sk [k];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < k; j++) begin
                        a_sk[j] <= '0;
                        b_sk[j] <= '0;
                    end
                end else if (en) begin
                    a_sk[0] <= a[SEG_W*k +: SEG_W];
                    b_sk[0] <= b[SEG_W*k +: SEG_W];
                    for (int j = 1; j < k; j++) begin
                        a_sk[j] <= a_sk[j-1];
                        b_sk[j] <= b_sk[j-1];
                    end
                end
            end

            assign x   = a_sk[k-1];
            assign y   = b_sk[k-1];
            assign ci  = stg[k-1].c;
            assign zin = stg[k-1].z;
            assign vin = stg[k-1].v;
        end

        sub_seg8 u_seg (
            .x    (x),
            .y    (y),
            .ci   (ci),
            .d    (d),
            .co   (co),
            .zero (zero)
        );

        // The last stage keeps the inverted carry so bout resets to 0.
        always_ff @(posedge clk) begin
            if (reset) begin
                q <= '0;
            end else if (en) begin
                q.d <= d;
                q.c <= (k == LAST) ? ~co : co;
                q.z <= zin & zero;
                q.v <= vin;
            end
        end

        assign stg[k] = q;

        if (k < LAST) begin : g_deskew
            localparam int DLY = LAST - k;
            logic [SEG_W-1:0] dq [DLY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < DLY; j++) dq[j] <= '0;
                end else if (en) begin
                    dq[0] <= stg[k].d;
                    for (int j = 1; j < DLY; j++) dq[j] <= dq[j-1];
                end
            end

            assign diff[SEG_W*k +: SEG_W] = dq[DLY-1];
        end else begin : g_msb
            assign diff[SEG_W*k +: SEG_W] = stg[k].d;
        end

`ifdef PIPE_SUB_CMP_OVF_EN
        if (k == LAST) begin : g_ovf
            // Carry into the MSB recovered from the sum bit: c7 = d7 ^ x7 ^ ~y7.
            always_ff @(posedge clk) begin
                if (reset)   ovf <= 1'b0;
                else if (en) ovf <= co ^ (d[SEG_W-1] ^ x[SEG_W-1] ^ ~y[SEG_W-1]);
            end
        end
`endif
    end

endmodule

// File: tb/tb_pipe_sub_cmp.sv
// Self-checking bench for pipe_sub_cmp (WIDTH=32); exercises the ovf port when
// PIPE_SUB_CMP_OVF_EN is defined.
module tb_pipe_sub_cmp;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         eq;
    } res_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, bin, out_valid, out_ready, bout, eq;
    logic [W-1:0] a, b, diff;
`ifdef PIPE_SUB_CMP_OVF_EN
    logic         ovf;
`endif

    int   tests = 0;
    int   fails = 0;
    res_t exp_q [$];

    always #5 clk = ~clk;

    pipe_sub_cmp #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .eq        (eq)
`ifdef PIPE_SUB_CMP_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Reference: plain wide unsigned subtraction.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        res_t         r;
        logic [W:0]   w;
        w      = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
        r.diff = w[W-1:0];
        r.bout = w[W];
        r.eq   = (w[W-1:0] == '0);
        return r;
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        longint s;
        s = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one isolated beat and collects its result and latency (-1 on timeout).
    task automatic run_single(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                              output res_t got, output logic got_ovf, output int lat);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        bin       = bi;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = -1;
        got      = '0;
        got_ovf  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid === 1'b1) begin
                lat = k;
                got = {diff, bout, eq};
`ifdef PIPE_SUB_CMP_OVF_EN
                got_ovf = ovf;
`endif
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = $urandom;
        b         = $urandom;
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        tests++;
        if ({diff, bout, eq} !== '0) begin fails++; $display("FAIL reset_data got=%h/%b/%b exp=0", diff, bout, eq); end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        res_t e1, e2;
        e1 = '{diff: 32'h0000_0002, bout: 1'b0, eq: 1'b0};
        e2 = '{diff: 32'h0000_0000, bout: 1'b0, eq: 1'b1};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 32'h0000_0005; b = 32'h0000_0003; bin = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            tests++;
            if (out_valid !== (k == 4 || k == 5))
                begin fails++; $display("FAIL b2b_valid cycle=%0d got=%b exp=%b", k, out_valid, (k == 4 || k == 5)); end
            if (k == 4) begin
                tests++;
                if ({diff, bout, eq} !== e1) begin fails++; $display("FAIL b2b_first got=%h exp=%h", {diff, bout, eq}, e1); end
            end
            if (k == 5) begin
                tests++;
                if ({diff, bout, eq} !== e2) begin fails++; $display("FAIL b2b_second got=%h exp=%h", {diff, bout, eq}, e2); end
            end
            if (k == 1) begin
                a = 32'h1234_5678; b = 32'h1234_5678;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_borrow();
        res_t got, e;
        logic o;
        int   lat;
        run_single(32'h0000_0000, 32'h0000_0001, 1'b0, got, o, lat);
        e = '{diff: 32'hFFFF_FFFF, bout: 1'b1, eq: 1'b0};
        tests++;
        if (lat != 4) begin fails++; $display("FAIL borrow_latency got=%0d exp=4", lat); end
        tests++;
        if (got !== e) begin fails++; $display("FAIL borrow_all got=%h exp=%h", got, e); end
        run_single(32'h0000_0100, 32'h0000_00FF, 1'b1, got, o, lat);
        e = '{diff: 32'h0000_0000, bout: 1'b0, eq: 1'b1};
        tests++;
        if (got !== e) begin fails++; $display("FAIL borrow_bin got=%h exp=%h", got, e); end
        run_single(32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b1, got, o, lat);
        e = '{diff: 32'hFFFF_FFFF, bout: 1'b1, eq: 1'b0};
        tests++;
        if (got !== e) begin fails++; $display("FAIL equal_with_bin got=%h exp=%h", got, e); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] sa [8];
        logic [W-1:0] sb [8];
        logic         sbin [8];
        logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic         exp_rdy, acc, hs, stall, any_extra;
        res_t         snap, e;
        int           sent = 0;
        int           recv = 0;
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom; sb[i] = $urandom; sbin[i] = 1'($urandom_range(0, 1));
        end
        sa[0] = '0; sb[0] = 32'd1; sbin[0] = 1'b0;
        sa[1] = 32'hDEAD_BEEF; sb[1] = 32'hDEAD_BEEF; sbin[1] = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
            in_valid  = (sent < 8);
            if (sent < 8) begin a = sa[sent]; b = sb[sent]; bin = sbin[sent]; end
            out_ready = pat[cyc % 4];
            #1;
            exp_rdy = out_ready | ~out_valid;
            tests++;
            if (in_ready !== exp_rdy) begin fails++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
            acc   = in_valid & exp_rdy;
            hs    = out_valid & out_ready;
            stall = out_valid & ~out_ready;
            snap  = {diff, bout, eq};
            if (acc) begin
                exp_q.push_back(model(sa[sent], sb[sent], sbin[sent]));
                sent++;
            end
            if (hs) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL bp_extra_beat got=%h exp=none", snap);
                end else begin
                    e = exp_q.pop_front();
                    if (snap !== e) begin fails++; $display("FAIL bp_result beat=%0d got=%h exp=%h", recv, snap, e); end
                end
                recv++;
            end
            tick();
            if (stall) begin
                tests++;
                if (out_valid !== 1'b1 || {diff, bout, eq} !== snap)
                    begin fails++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, {diff, bout, eq}, snap); end
            end
        end
        tests++;
        if (recv != 8) begin fails++; $display("FAIL bp_count got=%0d exp=8", recv); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        any_extra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) any_extra = 1'b1;
        end
        tests++;
        if (any_extra !== 1'b0 || exp_q.size() != 0)
            begin fails++; $display("FAIL bp_drain got=%b/%0d exp=0/0", any_extra, exp_q.size()); end
    endtask

    task automatic test_bubbles();
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic ev;
        res_t e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = (k < 5) ? pat[k] : 1'b0;
            a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
            if (in_valid) exp_q.push_back(model(a, b, bin));
            tick();
            ev = (k >= 3 && k < 8) ? pat[k-3] : 1'b0;
            tests++;
            if (out_valid !== ev) begin fails++; $display("FAIL bubble_valid cycle=%0d got=%b exp=%b", k + 1, out_valid, ev); end
            if (out_valid === 1'b1 && ev && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({diff, bout, eq} !== e) begin fails++; $display("FAIL bubble_data got=%h exp=%h", {diff, bout, eq}, e); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        res_t got;
        logic o;
        int   lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; bin = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL midreset_ready_low got=%b exp=0", in_ready); end
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL midreset_after got=%b/%b exp=0/1", out_valid, in_ready); end
        run_single(32'd9, 32'd4, 1'b0, got, o, lat);
        tests++;
        if (lat != 4 || got.diff !== 32'd5)
            begin fails++; $display("FAIL midreset_new got=%0d/%h exp=4/5", lat, got.diff); end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic         bi, o;
        res_t         got, e;
        int           lat;
        for (int i = 0; i < 10; i++) begin
            x = $urandom; y = (i % 3 == 0) ? x : W'($urandom); bi = 1'($urandom_range(0, 1));
            e = model(x, y, bi);
            run_single(x, y, bi, got, o, lat);
            tests++;
            if (lat != 4 || got !== e) begin fails++; $display("FAIL random_%0d got=%0d/%h exp=4/%h", i, lat, got, e); end
        end
    endtask

`ifdef PIPE_SUB_CMP_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] x, y;
        logic         bi, o, eo;
        res_t         got;
        int           lat;
        run_single(32'h8000_0000, 32'h0000_0001, 1'b0, got, o, lat);
        tests++;
        if (o !== 1'b1 || got.diff !== 32'h7FFF_FFFF || got.bout !== 1'b0)
            begin fails++; $display("FAIL ovf_min got=%b/%h/%b exp=1/7fffffff/0", o, got.diff, got.bout); end
        run_single(32'd5, 32'd3, 1'b0, got, o, lat);
        tests++;
        if (o !== 1'b0) begin fails++; $display("FAIL ovf_small got=%b exp=0", o); end
        for (int i = 0; i < 8; i++) begin
            x = $urandom; y = $urandom; bi = 1'($urandom_range(0, 1));
            eo = model_ovf(x, y, bi);
            run_single(x, y, bi, got, o, lat);
            tests++;
            if (o !== eo) begin fails++; $display("FAIL ovf_random_%0d got=%b exp=%b", i, o, eo); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0;
        test_reset();
        test_back_to_back();
        test_borrow();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
`ifdef PIPE_SUB_CMP_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
